d_to_sr_ff_bank: RTL and testbench

Bank of WIDTH SR flip-flops. Each bit is built from a D flip-flop plus next-state logic, which is the inverse of our SR-to-D conversion.
- Adds per-bank illegal-input (S=R=1) detection: a registered pulse, a sticky flag, and a saturating event counter.
- Used as the shared SR storage element in the flip-flop conversion library. Also used as the self-checking target in conversion benches.

---
 rtl/ff_conv_pkg.sv | 30 +++
 rtl/d_ff_ar.sv | 24 ++
 rtl/d_to_sr_ff_bank.sv | 85 ++++++++
 tb/tb_d_to_sr_ff_bank.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion library: illegal-input
// policy encodings and the SR next-state function reused by the JK/T blocks.
package ff_conv_pkg;

  localparam int unsigned ILL_HOLD   = 0;
  localparam int unsigned ILL_SET    = 1;
  localparam int unsigned ILL_RESET  = 2;
  localparam int unsigned ILL_TOGGLE = 3;

  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input logic [1:0] mode);
    logic d;
    d = q;
    case ({s, r})
      2'b00: d = q;
      2'b10: d = 1'b1;
      2'b01: d = 1'b0;
      default: begin
        case (mode)
          2'(ILL_SET):    d = 1'b1;
          2'(ILL_RESET):  d = 1'b0;
          2'(ILL_TOGGLE): d = ~q;
          default:        d = q;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/d_ff_ar.sv
// Single-bit D flip-flop with asynchronous active-low reset to a
// parameterised value.
module d_ff_ar #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= ResetVal;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/d_to_sr_ff_bank.sv
// Bank of SR flip-flops built from D flip-flops plus SR next-state logic,
// with illegal-input (S=R=1) pulse, sticky flag and saturating event counter.
module d_to_sr_ff_bank
  import ff_conv_pkg::*;
#(
  parameter int unsigned    WIDTH        = 4,
  parameter int unsigned    ILLEGAL_MODE = 0,
  parameter int unsigned    CNT_W        = 8,
  parameter logic [WIDTH-1:0] RESET_Q    = '0
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o,
  output logic             illegal_o,
  output logic             illegal_sticky_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  if (ILLEGAL_MODE > ILL_TOGGLE) begin : g_bad_mode
    $error("d_to_sr_ff_bank: ILLEGAL_MODE must be in 0..3");
  end

  localparam logic [1:0]       Mode   = ILLEGAL_MODE[1:0];
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign q_d[i] = en_i ? sr_next(s_i[i], r_i[i], q_q[i], Mode) : q_q[i];

    d_ff_ar #(
      .ResetVal(RESET_Q[i])
    ) u_ff (
      .clk_i(clk_i),
      .rst_n(rst_n),
      .d_i  (q_d[i]),
      .q_o  (q_q[i])
    );
  end

  // q and qb share one register so they can never disagree.
  assign q_o  = q_q;
  assign qb_o = ~q_q;

  logic             illegal_now;
  logic             illegal_q;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign illegal_now = en_i & (|(s_i & r_i));

  always_comb begin
    sticky_d = illegal_now | (sticky_q & ~clr_err_i);
    cnt_d    = cnt_q;
    if (clr_err_i) begin
      // A new event in the clearing cycle is kept, not lost.
      cnt_d = illegal_now ? CNT_W'(1) : '0;
    end else if (illegal_now && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= illegal_now;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
    end
  end

  assign illegal_o        = illegal_q;
  assign illegal_sticky_o = sticky_q;
  assign illegal_cnt_o    = cnt_q;

endmodule

// File: tb/tb_d_to_sr_ff_bank.sv
// Self-checking bench: four banks (one per illegal policy, 2-bit counter)
// driven in lockstep and compared against a behavioural scoreboard model.
module tb_d_to_sr_ff_bank;

  localparam logic [3:0] RST = 4'h9;

  typedef struct packed {
    logic [3:0][3:0] q;
    logic            ill;
    logic            sticky;
    logic [1:0]      cnt;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       clr;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n, en, clr;
  logic [3:0] s, r;

  logic [3:0] q_w   [4];
  logic [3:0] qb_w  [4];
  logic       ill_w [4];
  logic       stk_w [4];
  logic [1:0] cnt_w [4];

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t e;

  logic [3:0] mq [4];
  logic       m_ill, m_stk;
  logic [1:0] m_cnt;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    d_to_sr_ff_bank #(
      .WIDTH       (4),
      .ILLEGAL_MODE(m),
      .CNT_W       (2),
      .RESET_Q     (RST)
    ) u_dut (
      .clk_i           (clk),
      .rst_n           (rst_n),
      .en_i            (en),
      .s_i             (s),
      .r_i             (r),
      .clr_err_i       (clr),
      .q_o             (q_w[m]),
      .qb_o            (qb_w[m]),
      .illegal_o       (ill_w[m]),
      .illegal_sticky_o(stk_w[m]),
      .illegal_cnt_o   (cnt_w[m])
    );
  end

  task automatic model_reset();
    for (int m = 0; m < 4; m++) mq[m] = RST;
    m_ill = 1'b0;
    m_stk = 1'b0;
    m_cnt = 2'd0;
  endtask

  // Drive one cycle (called at negedge), push the model's expectation, clock it.
  task automatic cyc(input stim_t st);
    logic now;
    exp_t x;
    en  = st.en;
    s   = st.s;
    r   = st.r;
    clr = st.clr;
    now = st.en & (|(st.s & st.r));
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++) begin
        if (st.en) begin
          case ({st.s[i], st.r[i]})
            2'b10: mq[m][i] = 1'b1;
            2'b01: mq[m][i] = 1'b0;
            2'b11: begin
              if (m == 1) mq[m][i] = 1'b1;
              else if (m == 2) mq[m][i] = 1'b0;
              else if (m == 3) mq[m][i] = ~mq[m][i];
            end
            default: ;
          endcase
        end
      end
    end
    m_stk = now | (m_stk & ~st.clr);
    if (st.clr) m_cnt = now ? 2'd1 : 2'd0;
    else if (now && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    m_ill = now;
    for (int m = 0; m < 4; m++) x.q[m] = mq[m];
    x.ill    = m_ill;
    x.sticky = m_stk;
    x.cnt    = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    en = 1'b1; s = 4'hF; r = 4'h0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {RST, ~RST, 1'b0, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL reset_state mode%0d: got q=%h qb=%h ill=%b stk=%b cnt=%0d need q=%h qb=%h 0 0 0",
                 m, q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m], RST, ~RST);
      end
    end
    rst_n = 1'b1;
    cyc('{1'b1, 4'hF, 4'h0, 1'b0});
    e = sb.pop_front();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}
          || q_w[m] !== 4'hF) begin
        errors++;
        $display("FAIL first_update mode%0d: got q=%h cnt=%0d need q=%h cnt=%0d",
                 m, q_w[m], cnt_w[m], e.q[m], e.cnt);
      end
    end
  endtask

  task automatic test_set_reset_hold();
    stim_t t [5];
    t = '{'{1'b1, 4'h3, 4'hC, 1'b0}, '{1'b1, 4'h0, 4'h0, 1'b0}, '{1'b1, 4'h0, 4'h0, 1'b0},
          '{1'b1, 4'h0, 4'h0, 1'b0}, '{1'b0, 4'hF, 4'h0, 1'b0}};
    for (int k = 0; k < 5; k++) begin
      cyc(t[k]);
      e = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}
            || q_w[m] !== 4'b0011) begin
          errors++;
          $display("FAIL set_reset_hold step%0d mode%0d: got q=%h qb=%h need q=%h qb=%h",
                   k, m, q_w[m], qb_w[m], e.q[m], ~e.q[m]);
        end
      end
    end
  endtask

  task automatic test_illegal_policy();
    stim_t t [3];
    logic [3:0] pol [4];
    pol = '{4'h5, 4'hF, 4'h0, 4'hA};
    t = '{'{1'b1, 4'h5, 4'hA, 1'b0}, '{1'b1, 4'hF, 4'hF, 1'b0}, '{1'b1, 4'h0, 4'h0, 1'b0}};
    for (int k = 0; k < 3; k++) begin
      cyc(t[k]);
      e = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}) begin
          errors++;
          $display("FAIL illegal_policy step%0d mode%0d: got q=%h ill=%b stk=%b cnt=%0d need q=%h ill=%b stk=%b cnt=%0d",
                   k, m, q_w[m], ill_w[m], stk_w[m], cnt_w[m], e.q[m], e.ill, e.sticky, e.cnt);
        end
        if (k == 1) begin
          checks++;
          if (q_w[m] !== pol[m] || ill_w[m] !== 1'b1 || stk_w[m] !== 1'b1 || cnt_w[m] !== 2'd1) begin
            errors++;
            $display("FAIL policy_result mode%0d: got q=%h ill=%b stk=%b cnt=%0d need q=%h 1 1 1",
                     m, q_w[m], ill_w[m], stk_w[m], cnt_w[m], pol[m]);
          end
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 6; k++) begin
      if (k == 0) cyc('{1'b1, 4'h0, 4'h0, 1'b1});
      else cyc('{1'b1, 4'hF, 4'hF, 1'b0});
      e = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}
            || cnt_w[m] !== seq[k] || ill_w[m] !== (k != 0)) begin
          errors++;
          $display("FAIL saturation step%0d mode%0d: got q=%h ill=%b cnt=%0d need q=%h ill=%b cnt=%0d",
                   k, m, q_w[m], ill_w[m], cnt_w[m], e.q[m], e.ill, seq[k]);
        end
      end
    end
  endtask

  task automatic test_clr_collision();
    stim_t t [2];
    t = '{'{1'b1, 4'h0, 4'h0, 1'b1}, '{1'b1, 4'hF, 4'hF, 1'b1}};
    for (int k = 0; k < 2; k++) begin
      cyc(t[k]);
      e = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}
            || stk_w[m] !== (k == 1) || cnt_w[m] !== 2'(k)) begin
          errors++;
          $display("FAIL clr_collision step%0d mode%0d: got stk=%b cnt=%0d q=%h need stk=%b cnt=%0d q=%h",
                   k, m, stk_w[m], cnt_w[m], q_w[m], e.sticky, e.cnt, e.q[m]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t t [2];
    t = '{'{1'b1, 4'hF, 4'hF, 1'b0}, '{1'b1, 4'hA, 4'h5, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      cyc(t[k]);
      e = sb.pop_front();
      for (int m = 0; m < 4; m++) begin
        checks++;
        if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}
            || (k == 1 && (q_w[m] !== 4'hA || cnt_w[m] !== 2'd2))) begin
          errors++;
          $display("FAIL pre_async_reset step%0d mode%0d: got q=%h cnt=%0d need q=%h cnt=%0d",
                   k, m, q_w[m], cnt_w[m], e.q[m], e.cnt);
        end
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {RST, ~RST, 1'b0, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL async_reset mode%0d: got q=%h qb=%h ill=%b stk=%b cnt=%0d need q=%h qb=%h 0 0 0",
                 m, q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m], RST, ~RST);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc('{1'b1, 4'h0, 4'h0, 1'b0});
    e = sb.pop_front();
    for (int m = 0; m < 4; m++) begin
      checks++;
      if ({q_w[m], qb_w[m], ill_w[m], stk_w[m], cnt_w[m]} !== {e.q[m], ~e.q[m], e.ill, e.sticky, e.cnt}) begin
        errors++;
        $display("FAIL post_async_reset mode%0d: got q=%h cnt=%0d need q=%h cnt=%0d",
                 m, q_w[m], cnt_w[m], e.q[m], e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_reset_hold();
    test_illegal_policy();
    test_saturation();
    test_clr_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
